seven_seg_display_driver: RTL

Display-side consumer of the menu subsystem's 16-bit selected value and 4-bit decimal-point pattern. Converts the binary value to BCD with an iterative double-dabble engine, one bit per clock. Registers the result atomically and time-multiplexes it onto a 4-digit common-anode 7-segment display. Supports leading-zero blanking and overflow indication.

---
 rtl/seven_seg_display_driver_if.sv | 23 ++
 rtl/seven_seg_display_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_driver_if.sv
// Value/DP request from the menu and the latched BCD plus scanned display outputs.
// master drives the request side; slave is the display driver.
interface seven_seg_display_driver_if;
    logic [15:0] value_in;
    logic [3:0]  decimal_pt_in;
    logic        blank_leading_zeros;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        conv_done;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    modport master (
        output value_in, decimal_pt_in, blank_leading_zeros,
        input  bcd_out, overflow, conv_done, an_n, seg_n, dp_n
    );

    modport slave (
        input  value_in, decimal_pt_in, blank_leading_zeros,
        output bcd_out, overflow, conv_done, an_n, seg_n, dp_n
    );
endinterface

// File: rtl/seven_seg_display_driver.sv
// Binary-to-BCD (double dabble, 1 bit/clk) feeding a 4-digit multiplexed common-anode display.
// 18-cycle conversion period; display outputs lag one cycle; no backpressure, always running.
module seven_seg_display_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    seven_seg_display_driver_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [1:0]    state;
    logic [15:0]   shreg;
    logic [19:0]   acc;
    logic [19:0]   acc_adj;
    logic [3:0]    bit_cnt;
    logic [3:0]    dp_shadow;
    logic [15:0]   bcd_r;
    logic          ovf_r;
    logic          done_r;
    logic [3:0]    dp_reg;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM; display registers only change in LOAD so bcd_out never shows partial sums.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            acc       <= '0;
            bit_cnt   <= '0;
            dp_shadow <= '0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
            dp_reg    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    shreg     <= bus.value_in;
                    dp_shadow <= bus.decimal_pt_in;
                    acc       <= '0;
                    bit_cnt   <= '0;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc     <= {acc_adj[18:0], shreg[15]};
                    shreg   <= {shreg[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    bcd_r  <= acc[15:0];
                    ovf_r  <= |acc[19:16];
                    dp_reg <= dp_shadow;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    logic [15:0] hi_nibs;
    logic [3:0]  hi_dp;
    logic        blank;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    // A digit is a leading zero only if it and everything left of it is zero and carries no DP.
    always_comb begin
        hi_nibs = bcd_r >> {digit_idx, 2'b00};
        hi_dp   = dp_reg >> digit_idx;
        blank   = bus.blank_leading_zeros && (digit_idx != 2'd0) &&
                  (hi_nibs == 16'd0) && (hi_dp == 4'd0);
        seg_nxt = seg_decode(bcd_r[{digit_idx, 2'b00} +: 4]);
        dp_nxt  = ~dp_reg[digit_idx];
        if (ovf_r) begin
            seg_nxt = 7'h3F;
            dp_nxt  = 1'b1;
        end else if (blank) begin
            seg_nxt = 7'h7F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << digit_idx);
            seg_r <= seg_nxt;
            dp_r  <= dp_nxt;
        end
    end

    assign bus.bcd_out   = bcd_r;
    assign bus.overflow  = ovf_r;
    assign bus.conv_done = done_r;
    assign bus.an_n      = an_r;
    assign bus.seg_n     = seg_r;
    assign bus.dp_n      = dp_r;
endmodule
